// File: rtl/jtag_axil_master_engine.sv
// AXI4-Lite master engine: turns level-held decoder write/read requests into
// single AXI4-Lite transactions, with completion pulses and a hang timeout.
module jtag_axil_master_engine #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          sys_clk,
  input  logic                          sys_resetn,
  input  logic                          axi_write_req,
  input  logic                          axi_read_req,
  input  logic [AXI_ADDR_WIDTH-1:0]     req_addr,
  input  logic [AXI_DATA_WIDTH-1:0]     req_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   req_wstrb,
  output logic                          axi_write_done,
  output logic                          axi_read_done,
  output logic [AXI_DATA_WIDTH-1:0]     read_data_reg,
  output logic [1:0]                    resp_code,
  output logic                          timeout_flag,
  output logic                          busy,
  output logic [7:0]                    txn_count,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                    m_axi_arprot,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [2:0] {
    IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE, RELEASE
  } state_t;

  state_t        state_reg;
  logic [TW-1:0] timer_reg;
  logic          expired;
  logic          aw_ok;
  logic          w_ok;

  // Timer holds the number of cycles already spent in the active states, so
  // the abort lands on the TIMEOUT_CYCLES-th cycle after accept.
  assign expired = TIMEOUT_EN && (timer_reg == TIMER_LAST);
  // In WR a dropped valid means that channel was already accepted.
  assign aw_ok   = !m_axi_awvalid || m_axi_awready;
  assign w_ok    = !m_axi_wvalid  || m_axi_wready;

  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      axi_write_done <= 1'b0;
      axi_read_done  <= 1'b0;
      read_data_reg  <= '0;
      resp_code      <= 2'b00;
      timeout_flag   <= 1'b0;
      busy           <= 1'b0;
      txn_count      <= 8'd0;
      m_axi_awaddr   <= '0;
      m_axi_awvalid  <= 1'b0;
      m_axi_wdata    <= '0;
      m_axi_wstrb    <= '0;
      m_axi_wvalid   <= 1'b0;
      m_axi_bready   <= 1'b0;
      m_axi_araddr   <= '0;
      m_axi_arvalid  <= 1'b0;
      m_axi_rready   <= 1'b0;
    end else begin
      axi_write_done <= 1'b0;
      axi_read_done  <= 1'b0;
      if (state_reg inside {WR, WR_RESP, RD_ADDR, RD_DATA}) begin
        timer_reg <= timer_reg + 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (axi_write_req) begin
            m_axi_awaddr  <= req_addr;
            m_axi_wdata   <= req_wdata;
            m_axi_wstrb   <= req_wstrb;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            timer_reg     <= '0;
            busy          <= 1'b1;
            state_reg     <= WR;
          end else if (axi_read_req) begin
            m_axi_araddr  <= req_addr;
            m_axi_arvalid <= 1'b1;
            timer_reg     <= '0;
            busy          <= 1'b1;
            state_reg     <= RD_ADDR;
          end
        end
        WR: begin
          if (aw_ok && w_ok) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b1;
            state_reg     <= WR_RESP;
          end else if (expired) begin
            m_axi_awvalid  <= 1'b0;
            m_axi_wvalid   <= 1'b0;
            resp_code      <= 2'b11;
            timeout_flag   <= 1'b1;
            axi_write_done <= 1'b1;
            state_reg      <= DONE;
          end else begin
            if (m_axi_awready) m_axi_awvalid <= 1'b0;
            if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            resp_code      <= m_axi_bresp;
            m_axi_bready   <= 1'b0;
            axi_write_done <= 1'b1;
            state_reg      <= DONE;
          end else if (expired) begin
            resp_code      <= 2'b11;
            timeout_flag   <= 1'b1;
            m_axi_bready   <= 1'b0;
            axi_write_done <= 1'b1;
            state_reg      <= DONE;
          end
        end
        RD_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state_reg     <= RD_DATA;
          end else if (expired) begin
            m_axi_arvalid <= 1'b0;
            resp_code     <= 2'b11;
            timeout_flag  <= 1'b1;
            axi_read_done <= 1'b1;
            state_reg     <= DONE;
          end
        end
        RD_DATA: begin
          if (m_axi_rvalid) begin
            read_data_reg <= m_axi_rdata;
            resp_code     <= m_axi_rresp;
            m_axi_rready  <= 1'b0;
            axi_read_done <= 1'b1;
            state_reg     <= DONE;
          end else if (expired) begin
            m_axi_rready  <= 1'b0;
            resp_code     <= 2'b11;
            timeout_flag  <= 1'b1;
            axi_read_done <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          txn_count <= txn_count + 8'd1;
          state_reg <= RELEASE;
        end
        RELEASE: begin
          // A request still held from the finished transaction must not re-issue.
          if (!axi_write_req && !axi_read_req) begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_axil_master_engine.sv
// Directed bench for jtag_axil_master_engine: slave side driven cycle by cycle,
// outputs sampled on the falling edge against hand-computed values.
module tb_jtag_axil_master_engine;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          sys_clk = 1'b0;
  logic          sys_resetn = 1'b0;
  logic          write_req = 1'b0, read_req = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          write_done, read_done, timeout_flag, busy;
  logic [DW-1:0] read_data;
  logic [1:0]    resp_code;
  logic [7:0]    txn_count;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_wstrb;
  logic          awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]    bresp = 2'b00, rresp = 2'b00;
  logic [DW-1:0] rdata = '0;

  int n_assert = 0;
  int n_fail = 0;

  always #5 sys_clk = ~sys_clk;

  jtag_axil_master_engine #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk(sys_clk), .sys_resetn(sys_resetn),
    .axi_write_req(write_req), .axi_read_req(read_req),
    .req_addr(addr), .req_wdata(wdata), .req_wstrb(wstrb),
    .axi_write_done(write_done), .axi_read_done(read_done),
    .read_data_reg(read_data), .resp_code(resp_code),
    .timeout_flag(timeout_flag), .busy(busy), .txn_count(txn_count),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready),
    .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      tick();
    end
    chk(tag, busy, 1'b0);
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rready", rready, 0);
    chk("rst_done", {write_done, read_done}, 0);
    chk("rst_rdata", read_data, 0);
    chk("rst_resp", resp_code, 0);
    chk("rst_timeout", timeout_flag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_txn", txn_count, 0);
    chk("prot", {awprot, arprot}, 0);
    sys_resetn = 1'b1;
    tick();

    // Zero-wait write
    write_req = 1; addr = 32'h43C0_0000; wdata = 32'h1234_5678; wstrb = 4'hF;
    awready = 1; wready = 1;
    tick();
    chk("w1_awvalid", awvalid, 1);
    chk("w1_wvalid", wvalid, 1);
    chk("w1_busy", busy, 1);
    addr = 32'hDEAD_BEEF; wdata = 32'h0;
    tick();
    chk("w1_awaddr", awaddr, 32'h43C0_0000);
    chk("w1_wdata", m_wdata, 32'h1234_5678);
    chk("w1_wstrb", m_wstrb, 4'hF);
    chk("w1_valids_low", {awvalid, wvalid}, 0);
    chk("w1_bready", bready, 1);
    chk("w1_no_done_c2", write_done, 0);
    bvalid = 1; bresp = 2'b00;
    tick();
    chk("w1_done_c3", write_done, 1);
    chk("w1_resp", resp_code, 2'b00);
    chk("w1_bready_low", bready, 0);
    bvalid = 0; write_req = 0;
    tick();
    chk("w1_done_pulse", write_done, 0);
    chk("w1_txn", txn_count, 1);
    $display("txn write addr=0x43c00000 data=0x12345678 resp=%0d", resp_code);
    wait_idle("w1_idle");

    // Read: AR held two cycles, RVALID delayed
    read_req = 1; addr = 32'h43C0_0008; arready = 0;
    tick();
    chk("r1_arvalid", arvalid, 1);
    chk("r1_araddr", araddr, 32'h43C0_0008);
    chk("r1_awvalid", awvalid, 0);
    tick();
    chk("r1_ar_held", arvalid, 1);
    chk("r1_rready_early", rready, 0);
    arready = 1;
    tick();
    chk("r1_ar_drop", arvalid, 0);
    chk("r1_rready", rready, 1);
    arready = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("r1_wait_done", read_done, 0);
    end
    rvalid = 1; rdata = 32'hABCD_EF00; rresp = 2'b00;
    tick();
    chk("r1_done", read_done, 1);
    chk("r1_rdata", read_data, 32'hABCD_EF00);
    chk("r1_resp", resp_code, 2'b00);
    chk("r1_rready_low", rready, 0);
    rvalid = 0; rdata = 32'h0; read_req = 0;
    tick();
    chk("r1_done_pulse", read_done, 0);
    chk("r1_txn", txn_count, 2);
    $display("txn read addr=0x43c00008 data=0x%08h resp=%0d", read_data, resp_code);
    wait_idle("r1_idle");

    // W accepted 3 cycles before AW, SLVERR, request then held 20 cycles
    write_req = 1; addr = 32'h43C0_0010; wdata = 32'hA5A5_A5A5; wstrb = 4'h3;
    awready = 0; wready = 1;
    tick();
    chk("w2_both_valid", {awvalid, wvalid}, 2'b11);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("w2_w_drop_aw_held", {awvalid, wvalid}, 2'b10);
    end
    awready = 1;
    tick();
    chk("w2_aw_drop", awvalid, 0);
    chk("w2_bready", bready, 1);
    chk("w2_no_early_done", write_done, 0);
    awready = 0; bvalid = 1; bresp = 2'b10;
    tick();
    chk("w2_done", write_done, 1);
    chk("w2_resp_slverr", resp_code, 2'b10);
    chk("w2_wstrb", m_wstrb, 4'h3);
    bvalid = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_no_done", write_done, 0);
      chk("hold_no_reissue", {awvalid, wvalid, arvalid}, 0);
      chk("hold_busy", busy, 1);
    end
    chk("w2_txn", txn_count, 3);
    $display("txn write addr=0x43c00010 data=0xa5a5a5a5 resp=%0d", resp_code);
    write_req = 0;
    tick();
    chk("release_idle", busy, 0);
    chk("release_no_txn", awvalid, 0);

    // Simultaneous write+read: write wins, no AR
    write_req = 1; read_req = 1; addr = 32'h43C0_0020; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
    awready = 1; wready = 1;
    tick();
    chk("wr_both_aw", {awvalid, wvalid}, 2'b11);
    chk("wr_both_no_ar", arvalid, 0);
    tick();
    chk("wr_both_bready", bready, 1);
    chk("wr_both_no_ar2", arvalid, 0);
    bvalid = 1; bresp = 2'b00;
    tick();
    chk("wr_both_wdone", write_done, 1);
    chk("wr_both_no_rdone", read_done, 0);
    bvalid = 0; write_req = 0; read_req = 0;
    tick();
    chk("wr_both_txn", txn_count, 4);
    $display("txn write addr=0x43c00020 data=0xcafef00d resp=%0d", resp_code);
    wait_idle("wr_both_idle");

    // Timeout: AW never accepted
    write_req = 1; addr = 32'h43C0_0040; wdata = 32'h5555_AAAA; wstrb = 4'hF;
    awready = 0; wready = 1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("to_no_done", write_done, 0);
    end
    chk("to_aw_held", awvalid, 1);
    chk("to_flag_early", timeout_flag, 0);
    tick();
    chk("to_done_c17", write_done, 1);
    chk("to_resp", resp_code, 2'b11);
    chk("to_flag", timeout_flag, 1);
    chk("to_valids_low", {awvalid, wvalid, bready}, 0);
    chk("to_rdata_kept", read_data, 32'hABCD_EF00);
    write_req = 0;
    tick();
    chk("to_txn", txn_count, 5);
    chk("to_flag_sticky", timeout_flag, 1);
    $display("txn write addr=0x43c00040 timeout resp=%0d", resp_code);
    wait_idle("to_idle");

    // Reset during RD_DATA
    read_req = 1; addr = 32'h43C0_0030; arready = 1;
    tick();
    chk("rr_arvalid", arvalid, 1);
    tick();
    chk("rr_rready", rready, 1);
    rvalid = 1; rdata = 32'h1111_2222;
    sys_resetn = 0;
    #1;
    chk("rr_rready_async", rready, 0);
    chk("rr_busy_async", busy, 0);
    tick();
    chk("rr_no_done", read_done, 0);
    chk("rr_rdata_cleared", read_data, 0);
    chk("rr_txn_cleared", txn_count, 0);
    chk("rr_flag_cleared", timeout_flag, 0);
    read_req = 0; rvalid = 0; arready = 0;
    sys_resetn = 1;
    tick();
    chk("rr_post_no_done", read_done, 0);
    chk("rr_post_idle", {arvalid, rready, busy}, 0);
    $display("txn read addr=0x43c00030 aborted by reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
